pipelined_decode: RTL and testbench
===================================

PIPELINED_DECODE -- requirements
Module: pipelined_decode

Interface
REQ-001 SHALL have parameters (name, default, meaning): WORD, 64, datapath width; INSTR_LEN, 32, instruction width; NUM_REGS, 32, register count (power of two; index NUM_REGS-1 is XZR).
REQ-002 SHALL have these ports (name, direction, width, meaning). One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this edge
- instruction  in  INSTR_LEN  LEGv8 instruction
- in_pc  in  WORD  PC of instruction
- wb_en  in  1  write-back strobe
- wb_addr  in  log2(NUM_REGS)  write-back register
- wb_data  in  WORD  write-back data
- flush  in  1  kill held output
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- opcode  out  11  instruction[31:21]
- sign_extended_output  out  WORD  immediate
- read_data1, read_data2  out  WORD each  operands
- out_rd  out  log2(NUM_REGS)  instruction[4:0]
- out_pc  out  WORD  registered in_pc
- reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control
- alu_op  out  2  ALU class
- illegal  out  1  unknown opcode
- stall  out  1  load-use hazard active

Function
REQ-003 Register file SHALL hold NUM_REGS x WORD; write at posedge when wb_en and wb_addr != NUM_REGS-1; XZR SHALL always read 0.
REQ-004 Read addresses: port1 = instruction[9:5]; port2 = reg2_loc ? instruction[4:0] : instruction[20:16].
REQ-005 Reads SHALL bypass: a same-cycle wb_en to a read address (non-XZR) SHALL return wb_data.
REQ-006 Decode table: LDUR 11111000010 -> alu_src, mem_to_reg, reg_write, mem_read, alu_op=00; STUR 11111000000 -> reg2_loc, alu_src, mem_write, alu_op=00; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> reg_write, alu_op=10; CBZ/CBNZ 1011010x -> reg2_loc, branch, alu_op=01; B 000101 -> uncondbranch, alu_op=00. All unlisted controls 0.
REQ-007 Unlisted opcode SHALL drive all controls 0 and illegal=1; the bundle still issues.
REQ-008 Immediate SHALL be sign-extended to WORD: D-type [20:12], CB [23:5], B [25:0]; R-type 0.
REQ-009 Outputs SHALL be registered; latency 1 cycle from acceptance (in_valid && in_ready) to out_valid.
REQ-010 in_ready = (!out_valid || out_ready) && !stall.
REQ-011 stall SHALL be 1 when out_valid && mem_read && out_rd != XZR and out_rd matches the incoming port1 address or the incoming port2 address of an instruction that reads port2 (R-type, STUR, CB).
REQ-012 During stall with out_ready=1, out_valid SHALL become 0 next edge (bubble); the incoming instruction is accepted the following cycle.
REQ-013 While out_valid && !out_ready, a wb_en matching the held instruction's port1/port2 address (non-XZR) SHALL update held read_data1/read_data2.
REQ-014 flush SHALL clear out_valid at the next edge and take priority over acceptance; in_ready is unaffected by flush.
REQ-015 out_valid and data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-016 rst_n low SHALL asynchronously clear out_valid, all controls, illegal, opcode, sign_extended_output, read_data1/2, out_rd, out_pc and every register to 0.
REQ-017 Reset mid-operation SHALL discard the held bundle; first acceptance is possible on the first edge after rst_n rises.

Verification
REQ-018 X22=16, issue 0xF84402C9 (LDUR X9,[X22,#64]) -> next cycle opcode=11111000010, imm=64, read_data1=16, mem_read=mem_to_reg=alu_src=reg_write=1, alu_op=00.
REQ-019 wb_en X9=20 in the same cycle ADD 0x8B09026A (X10,X19,X9) is accepted -> read_data2=20, alu_op=10, reg_write=1.
REQ-020 Issue 0xB5FFFF6B -> imm=0xFFFFFFFFFFFFFFFB, branch=1, reg2_loc=1, alu_op=01; 0x17FFFFC9 -> imm=-55, uncondbranch=1.
REQ-021 LDUR X9 held valid, next offered ADD using X9 -> stall=1, in_ready=0, one bubble (out_valid=0), then ADD issues.
REQ-022 wb_addr=31 data 5, then ORR reading X31 -> operand 0; opcode 0x7FF -> illegal=1, controls 0.
REQ-023 flush with held bundle -> out_valid=0 next edge; rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipelined_decode.sv
// LEGv8 decode stage: register file with write-back bypass, control/immediate
// decode, and a one-entry output register with ready/valid flow control.
module pipelined_decode #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_LEN-1:0]        instruction,
  input  logic [WORD-1:0]             in_pc,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [WORD-1:0]             wb_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [10:0]                 opcode,
  output logic [WORD-1:0]             sign_extended_output,
  output logic [WORD-1:0]             read_data1,
  output logic [WORD-1:0]             read_data2,
  output logic [$clog2(NUM_REGS)-1:0] out_rd,
  output logic [WORD-1:0]             out_pc,
  output logic                        reg2_loc,
  output logic                        uncondbranch,
  output logic                        branch,
  output logic                        mem_read,
  output logic                        mem_to_reg,
  output logic                        mem_write,
  output logic                        alu_src,
  output logic                        reg_write,
  output logic [1:0]                  alu_op,
  output logic                        illegal,
  output logic                        stall
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);
  // ctrl bits: reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0]
  localparam logic [9:0] CTRL_LDUR = 10'b0001101100;
  localparam logic [9:0] CTRL_STUR = 10'b1000011000;
  localparam logic [9:0] CTRL_R    = 10'b0000000110;
  localparam logic [9:0] CTRL_CB   = 10'b1010000001;
  localparam logic [9:0] CTRL_B    = 10'b0100000000;

  logic [WORD-1:0] regs_q [NUM_REGS];
  logic [WORD-1:0] regs_d [NUM_REGS];

  logic            out_valid_q, out_valid_d;
  logic [10:0]     opcode_q, opcode_d;
  logic [WORD-1:0] imm_q, imm_d;
  logic [WORD-1:0] rd1_q, rd1_d;
  logic [WORD-1:0] rd2_q, rd2_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [9:0]      ctrl_q, ctrl_d;
  logic            illegal_q, illegal_d;

  logic [10:0]     op_s;
  logic [9:0]      ctrl_s;
  logic            illegal_s;
  logic            reads2_s;
  logic [WORD-1:0] imm_s;
  logic [AW-1:0]   ra1_s, ra2_s;
  logic [WORD-1:0] rdata1_s, rdata2_s;
  logic            stall_s, in_ready_s, accept_s;

  assign op_s = instruction[31:21];

  // Opcode decode: control vector, immediate format, and whether port2 is a real operand
  always_comb begin
    ctrl_s    = 10'b0;
    illegal_s = 1'b0;
    reads2_s  = 1'b0;
    imm_s     = '0;
    casez (op_s)
      11'b11111000010: begin
        ctrl_s = CTRL_LDUR;
        imm_s  = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b11111000000: begin
        ctrl_s   = CTRL_STUR;
        reads2_s = 1'b1;
        imm_s    = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        ctrl_s   = CTRL_R;
        reads2_s = 1'b1;
      end
      11'b1011010????: begin
        ctrl_s   = CTRL_CB;
        reads2_s = 1'b1;
        imm_s    = {{(WORD-19){instruction[23]}}, instruction[23:5]};
      end
      11'b000101?????: begin
        ctrl_s = CTRL_B;
        imm_s  = {{(WORD-26){instruction[25]}}, instruction[25:0]};
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign ra1_s = instruction[AW+4:5];
  assign ra2_s = ctrl_s[9] ? instruction[AW-1:0] : instruction[AW+15:16];

  // Operand read with same-cycle write-back bypass; XZR always reads zero
  always_comb begin
    if (ra1_s == XZR) rdata1_s = '0;
    else if (wb_en && (wb_addr == ra1_s)) rdata1_s = wb_data;
    else rdata1_s = regs_q[ra1_s];
    if (ra2_s == XZR) rdata2_s = '0;
    else if (wb_en && (wb_addr == ra2_s)) rdata2_s = wb_data;
    else rdata2_s = regs_q[ra2_s];
  end

  assign stall_s = in_valid && out_valid_q && ctrl_q[6] && (rd_q != XZR) &&
                   ((rd_q == ra1_s) || (reads2_s && (rd_q == ra2_s)));
  assign in_ready_s = (!out_valid_q || out_ready) && !stall_s;
  assign accept_s   = in_valid && in_ready_s;

  // Register file write; XZR is never written
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_addr != XZR)) regs_d[wb_addr] = wb_data;
    else regs_d = regs_q;
  end

  // Output register: flush beats acceptance; a held bundle tracks write-backs to its sources
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    imm_d       = imm_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      opcode_d    = op_s;
      imm_d       = imm_s;
      rd1_d       = rdata1_s;
      rd2_d       = rdata2_s;
      rd_d        = instruction[AW-1:0];
      rs1_d       = ra1_s;
      rs2_d       = ra2_s;
      pc_d        = in_pc;
      ctrl_d      = ctrl_s;
      illegal_d   = illegal_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && wb_en && (wb_addr != XZR)) begin
      if (wb_addr == rs1_q) rd1_d = wb_data;
      else rd1_d = rd1_q;
      if (wb_addr == rs2_q) rd2_d = wb_data;
      else rd2_d = rd2_q;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Register file state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Output bundle state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= 11'b0;
      imm_q       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      pc_q        <= '0;
      ctrl_q      <= 10'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      imm_q       <= imm_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready             = in_ready_s;
  assign stall                = stall_s;
  assign out_valid            = out_valid_q;
  assign opcode               = opcode_q;
  assign sign_extended_output = imm_q;
  assign read_data1           = rd1_q;
  assign read_data2           = rd2_q;
  assign out_rd               = rd_q;
  assign out_pc               = pc_q;
  assign reg2_loc             = ctrl_q[9];
  assign uncondbranch         = ctrl_q[8];
  assign branch               = ctrl_q[7];
  assign mem_read             = ctrl_q[6];
  assign mem_to_reg           = ctrl_q[5];
  assign mem_write            = ctrl_q[4];
  assign alu_src              = ctrl_q[3];
  assign reg_write            = ctrl_q[2];
  assign alu_op               = ctrl_q[1:0];
  assign illegal              = illegal_q;

endmodule

// File: tb/tb_pipelined_decode.sv
// Self-checking bench for pipelined_decode: expected bundles are queued on
// acceptance and compared when the DUT hands them downstream.
module tb_pipelined_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instruction;
  logic [63:0] in_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [10:0] opcode;
  logic [63:0] sign_extended_output, read_data1, read_data2, out_pc;
  logic [4:0]  out_rd;
  logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic        illegal, stall;

  typedef struct packed {
    logic [10:0] op;
    logic [63:0] imm;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic [9:0]  ctrl;
    logic        ill;
  } bundle_t;

  localparam logic [9:0] C_LDUR = 10'b0001101100;
  localparam logic [9:0] C_STUR = 10'b1000011000;
  localparam logic [9:0] C_R    = 10'b0000000110;
  localparam logic [9:0] C_CB   = 10'b1010000001;
  localparam logic [9:0] C_B    = 10'b0100000000;
  localparam logic [31:0] I_LDUR = 32'hF84402C9;
  localparam logic [31:0] I_ADD  = 32'h8B09026A;

  bundle_t sb[$];
  int errors = 0;
  int checks = 0;

  pipelined_decode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .sign_extended_output(sign_extended_output),
    .read_data1(read_data1), .read_data2(read_data2), .out_rd(out_rd), .out_pc(out_pc),
    .reg2_loc(reg2_loc), .uncondbranch(uncondbranch), .branch(branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
    .illegal(illegal), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [10:0] op, input logic [63:0] imm,
                                 input logic [63:0] rd1, input logic [63:0] rd2,
                                 input logic [4:0] rd, input logic [63:0] pc,
                                 input logic [9:0] ctrl, input logic ill);
    bundle_t b;
    b.op = op; b.imm = imm; b.rd1 = rd1; b.rd2 = rd2;
    b.rd = rd; b.pc = pc; b.ctrl = ctrl; b.ill = ill;
    return b;
  endfunction

  // Scoreboard: compare every bundle that transfers downstream
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      bundle_t act, exp_b;
      act = mk(opcode, sign_extended_output, read_data1, read_data2, out_rd, out_pc,
               {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write,
                alu_src, reg_write, alu_op}, illegal);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bundle_unexpected got=%h", act);
      end else begin
        exp_b = sb.pop_front();
        if (act !== exp_b) begin
          errors++;
          $display("FAIL bundle pc=%h got=%h want=%h", exp_b.pc, act, exp_b);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [63:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc,
                       input bundle_t e, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    instruction = instr; in_pc = pc; in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      waited++;
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL offer_timeout pc=%h got=not_accepted want=accepted", pc);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({out_valid, opcode, sign_extended_output, read_data1, read_data2, out_rd, out_pc,
         reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src,
         reg_write, alu_op, illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b op=%h want=all zero", out_valid, opcode);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ldur;
    int w;
    wb_write(5'd22, 64'd16);
    offer(I_LDUR, 64'h100, mk(11'b11111000010, 64'd64, 64'd16, 64'd0, 5'd9, 64'h100, C_LDUR, 1'b0), w);
    idle(2);
  endtask

  task automatic test_bypass_add;
    int w;
    wb_write(5'd19, 64'd3);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'd20;
    offer(I_ADD, 64'h104, mk(11'b10001011000, 64'd0, 64'd3, 64'd20, 5'd10, 64'h104, C_R, 1'b0), w);
    wb_en = 1'b0;
    idle(2);
  endtask

  task automatic test_branch;
    int w;
    wb_write(5'd11, 64'h55);
    offer(32'hB5FFFF6B, 64'h108, mk(11'b10110101111, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'h55, 5'd11, 64'h108, C_CB, 1'b0), w);
    offer(32'h17FFFFC9, 64'h10C, mk(11'b00010111111, -64'sd55, 64'd0, 64'd0, 5'd9, 64'h10C, C_B, 1'b0), w);
    idle(2);
  endtask

  task automatic test_load_use;
    int w;
    offer(I_LDUR, 64'h200, mk(11'b11111000010, 64'd64, 64'd16, 64'd0, 5'd9, 64'h200, C_LDUR, 1'b0), w);
    instruction = I_ADD; in_pc = 64'h204; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_use_stall got stall=%b in_ready=%b want stall=1 in_ready=0", stall, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_use_bubble got out_valid=%b stall=%b in_ready=%b want 0 0 1", out_valid, stall, in_ready);
    end
    sb.push_back(mk(11'b10001011000, 64'd0, 64'd3, 64'd20, 5'd10, 64'h204, C_R, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_xzr_illegal;
    int w;
    wb_write(5'd31, 64'd5);
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'd5;
    offer({11'b10101010000, 5'd31, 6'd0, 5'd31, 5'd1}, 64'h240,
          mk(11'b10101010000, 64'd0, 64'd0, 64'd0, 5'd1, 64'h240, C_R, 1'b0), w);
    wb_en = 1'b0;
    offer(32'hFFE00000, 64'h244, mk(11'h7FF, 64'd0, 64'd0, 64'd0, 5'd0, 64'h244, 10'b0, 1'b1), w);
    idle(2);
  endtask

  task automatic test_held_update;
    int w;
    out_ready = 1'b0;
    offer(I_ADD, 64'h300, mk(11'b10001011000, 64'd0, 64'h77, 64'h99, 5'd10, 64'h300, C_R, 1'b0), w);
    wb_en = 1'b1; wb_addr = 5'd19; wb_data = 64'h77;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_handshake got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    wb_addr = 5'd9; wb_data = 64'h99;
    @(negedge clk);
    checks++;
    if (read_data1 !== 64'h77) begin
      errors++;
      $display("FAIL held_rd1_update got=%h want=%h", read_data1, 64'h77);
    end
    @(posedge clk); #1;
    wb_en = 1'b0;
    @(negedge clk);
    checks++;
    if (read_data2 !== 64'h99 || out_valid !== 1'b1 || opcode !== 11'b10001011000) begin
      errors++;
      $display("FAIL held_rd2_update got=%h valid=%b want=%h valid=1", read_data2, out_valid, 64'h99);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_flush;
    int w;
    out_ready = 1'b0;
    offer(I_ADD, 64'h400, mk(11'b10001011000, 64'd0, 64'h77, 64'h99, 5'd10, 64'h400, C_R, 1'b0), w);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got=%b want=0", out_valid);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk); #1;
    out_ready = 1'b1; flush = 1'b1;
    instruction = I_ADD; in_pc = 64'h404; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority got=%b want=0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int w;
    offer({11'b11111000000, 9'd8, 2'b00, 5'd22, 5'd9}, 64'h500,
          mk(11'b11111000000, 64'd8, 64'd16, 64'h99, 5'd9, 64'h500, C_STUR, 1'b0), w);
    offer({11'b11001011000, 5'd22, 6'd0, 5'd9, 5'd3}, 64'h504,
          mk(11'b11001011000, 64'd0, 64'h99, 64'd16, 5'd3, 64'h504, C_R, 1'b0), w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL back_to_back_wait got=%0d want=1", w);
    end
    offer({11'b10001010000, 5'd19, 6'd0, 5'd22, 5'd4}, 64'h508,
          mk(11'b10001010000, 64'd0, 64'd16, 64'h77, 5'd4, 64'h508, C_R, 1'b0), w);
    idle(2);
  endtask

  task automatic test_reset_mid;
    int w;
    out_ready = 1'b0;
    offer(I_ADD, 64'h600, mk(11'b10001011000, 64'd0, 64'h77, 64'h99, 5'd10, 64'h600, C_R, 1'b0), w);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || read_data1 !== 64'd0 || read_data2 !== 64'd0 ||
        opcode !== 11'd0 || out_pc !== 64'd0 || reg_write !== 1'b0 || alu_op !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid got valid=%b rd1=%h op=%h pc=%h want all zero", out_valid, read_data1, opcode, out_pc);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    offer(I_ADD, 64'h604, mk(11'b10001011000, 64'd0, 64'd0, 64'd0, 5'd10, 64'h604, C_R, 1'b0), w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL reset_first_accept got=%0d want=1", w);
    end
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instruction = 32'd0; in_pc = 64'd0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0; flush = 1'b0; out_ready = 1'b1;
    idle(2);
    test_reset();
    test_ldur();
    test_bypass_add();
    test_branch();
    test_load_use();
    test_xzr_illegal();
    test_held_update();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
